rf_exec_ctrl: RTL
=================

Name: rf_exec_ctrl

Overview:
- Execute/writeback sequencer that sits directly upstream of the 4-bit, 4-entry register file (2-bit addresses, combinational reads, write on posedge clk when reg_write is high).
- Accepts one 9-bit instruction per valid/ready handshake and drives the register file read addresses.
- Latches the operands, computes a 4-bit ALU result, drives the register file write port for exactly one cycle, and pulses done.
- Multicycle, non-pipelined: one instruction in flight at a time.

Parameters:
- DATA_W, 4, operand/result width; must match the register file data width.
- ADDR_W, 2, register address width; must match the register file address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction.
- instr  in  9  op[8:6], rd[5:4], rs1[3:2], rs2[1:0].
- rf_read_addr1  out  ADDR_W  to register file read_addr1.
- rf_read_addr2  out  ADDR_W  to register file read_addr2.
- rf_read_data1  in  DATA_W  from register file read_data1.
- rf_read_data2  in  DATA_W  from register file read_data2.
- rf_write_addr  out  ADDR_W  to register file write_addr.
- rf_write_data  out  DATA_W  to register file write_data.
- rf_reg_write  out  1  to register file reg_write.
- done  out  1  one-cycle pulse when the instruction retires.
- flag_zero  out  1  last retired result == 0.
- flag_carry  out  1  carry-out (ADD) or borrow (SUB) of the last ADD/SUB.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV (rd=rs1), 6 LDI (rd={rs1,rs2} as 4-bit immediate), 7 NOP.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr into ir and go to EXEC.
- EXEC:
  - rf_read_addr1=ir.rs1, rf_read_addr2=ir.rs2 (these also hold ir fields in every other state).
  - Latch rf_read_data1/2 into opa/opb.
  - Go to WB.
- WB:
  - Combinational ALU on opa/opb/ir.op.
  - rf_write_addr=ir.rd, rf_write_data=result.
  - rf_reg_write=1 for all ops except NOP.
  - done=1; flags update on this posedge; return to IDLE.
- Latency: accept edge T, done high in cycle T+2. Throughput is one instruction per 3 cycles; instr_ready is 0 during EXEC and WB.
- Arithmetic:
  - ADD: 5-bit sum; result = low 4 bits; carry = bit 4.
  - SUB: a-b mod 16; carry = borrow (a<b).
  - Logic ops, MOV and LDI leave flag_carry unchanged.
- flag_zero:
  - Updated for every op except NOP.
  - NOP retires with done=1 and leaves both flags unchanged.
- Read-after-write: back-to-back dependent instructions read the correct value. The register file write lands at the WB edge, before the next EXEC.
- Reset (asynchronous, any state):
  - State=IDLE; ir, opa, opb = 0.
  - rf_reg_write=0, done=0, flags=0.
  - rf_write_data=0, rf_write_addr=0, address outputs=0.
  - An instruction in flight is dropped and no write occurs.
- instr_valid while not ready is ignored. The upstream block holds instr until the handshake completes.

Optional Feature:
- RF_EXEC_SAT_EN defined:
  - ADD saturates to 4'hF on carry; SUB saturates to 4'h0 on borrow.
  - flag_carry still reports the raw carry/borrow.
- Not defined: modular wrap as above.

Decomposition:
- Package rf_exec_pkg:
  - Opcode constants OP_ADD..OP_NOP.
  - FSM state encoding (IDLE=0, EXEC=1, WB=2).
  - Instruction field bit positions.
  - DATA_W/ADDR_W defaults.
- One combinational sub-module, rf_exec_alu:
  - Inputs: op, a, b, imm.
  - Outputs: result, carry, zero.
  - Contains the saturation logic under the macro.

Test Plan:
- Reset mid-EXEC: assert rst_n=0 during EXEC of ADD r1 -> rf_reg_write never asserted, r1 unchanged, instr_ready=1 after release.
- LDI r0,#9; LDI r1,#8; ADD r2,r0,r1 -> r2=4'h1, flag_carry=1, flag_zero=0. With RF_EXEC_SAT_EN: r2=4'hF, flag_carry=1.
- SUB r3,r1,r1 with r1=8 -> r3=0, flag_zero=1, flag_carry=0. Then SUB r3,r0,r1 with r0=2 -> r3=4'hA, carry=1 (with RF_EXEC_SAT_EN: r3=0).
- Dependent chain LDI r0,#5; MOV r1,r0; XOR r2,r1,r0 -> r1=5, r2=0, flag_zero=1; done pulses exactly 3 times, each 2 cycles after its accept edge.
- NOP after ADD that set carry=1 -> done=1, rf_reg_write=0, flags unchanged.
- instr_valid held high continuously with changing instr -> instr_ready low in EXEC/WB; only instructions present on the accept edges execute.

Source files
------------

// File: rtl/rf_exec_pkg.sv
// rtl/rf_exec_pkg.sv - shared constants, opcodes and FSM encoding for the execute/writeback sequencer
package rf_exec_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 2;
    localparam int INSTR_W    = 9;
    localparam int OP_W       = 3;

    // instr = {op[8:6], rd[5:4], rs1[3:2], rs2[1:0]}
    localparam int OP_LSB  = 6;
    localparam int RD_LSB  = 4;
    localparam int RS1_LSB = 2;
    localparam int RS2_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MOV = 3'd5,
        OP_LDI = 3'd6,
        OP_NOP = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/rf_exec_alu.sv
// rtl/rf_exec_alu.sv - combinational ALU; RF_EXEC_SAT_EN makes ADD/SUB saturate instead of wrap
module rf_exec_alu
    import rf_exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

`ifdef RF_EXEC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                if (SAT_EN && carry) result = '1;
            end
            OP_SUB: begin
                // top bit of the widened difference is the borrow (a < b)
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
                if (SAT_EN && carry) result = '0;
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = a;
            OP_LDI:  result = imm;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/rf_exec_ctrl.sv
// rtl/rf_exec_ctrl.sv - multicycle IDLE/EXEC/WB sequencer driving a small register file (option RF_EXEC_SAT_EN in ALU)
module rf_exec_ctrl
    import rf_exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  rf_read_addr1,
    output logic [ADDR_W-1:0]  rf_read_addr2,
    input  logic [DATA_W-1:0]  rf_read_data1,
    input  logic [DATA_W-1:0]  rf_read_data2,
    output logic [ADDR_W-1:0]  rf_write_addr,
    output logic [DATA_W-1:0]  rf_write_data,
    output logic               rf_reg_write,
    output logic               done,
    output logic               flag_zero,
    output logic               flag_carry
);

    state_t              state, state_next;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   opa, opb, imm, alu_result;
    logic                alu_carry, alu_zero;
    op_t                 ir_op;
    logic [ADDR_W-1:0]   ir_rd, ir_rs1, ir_rs2;

    assign ir_op  = op_t'(ir[OP_LSB +: OP_W]);
    assign ir_rd  = ir[RD_LSB +: ADDR_W];
    assign ir_rs1 = ir[RS1_LSB +: ADDR_W];
    assign ir_rs2 = ir[RS2_LSB +: ADDR_W];
    assign imm    = DATA_W'({ir_rs1, ir_rs2});

    // Addresses follow ir in every state, so they read 0 straight out of reset.
    assign rf_read_addr1 = ir_rs1;
    assign rf_read_addr2 = ir_rs2;
    assign rf_write_addr = ir_rd;

    rf_exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (ir_op),
        .a      (opa),
        .b      (opb),
        .imm    (imm),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        instr_ready   = 1'b0;
        done          = 1'b0;
        rf_reg_write  = 1'b0;
        rf_write_data = '0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = EXEC;
            end
            EXEC: state_next = WB;
            WB: begin
                done          = 1'b1;
                rf_reg_write  = (ir_op != OP_NOP);
                rf_write_data = alu_result;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir         <= '0;
            opa        <= '0;
            opb        <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            case (state)
                IDLE: if (instr_valid) ir <= instr;
                EXEC: begin
                    opa <= rf_read_data1;
                    opb <= rf_read_data2;
                end
                WB: begin
                    if (ir_op != OP_NOP) flag_zero <= alu_zero;
                    if (ir_op == OP_ADD || ir_op == OP_SUB) flag_carry <= alu_carry;
                end
                default: ;
            endcase
        end
    end

endmodule
